// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, oversampled bit recovery, 8N1 with optional odd/even parity.
// States: IDLE wait start | START mid-bit check | DATA shift bits | PARITY check | STOP sample | BREAK wait line high
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 sample_tick_i,
  input  logic                 rx_in_i,
  input  logic [1:0]           parity_type_i,
  output logic [DATA_BITS-1:0] data_out_o,
  output logic                 data_valid_o,
  output logic                 parity_error_o,
  output logic                 stop_error_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           par_type_q;
  logic                 par_mis_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 valid_q, perr_q, serr_q;
  logic                 rxs, par_en, par_exp, busy_d;

  assign rxs     = rx_sync_q;
  assign par_en  = par_type_q[0] ^ par_type_q[1];
  // Even parity expects the XOR of the data; odd expects its inverse.
  assign par_exp = (par_type_q == 2'b10) ? (^shift_q) : ~(^shift_q);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sample_tick_i) begin
      case (state_q)
        S_IDLE:   if (!rxs) state_d = S_START;
        S_START:  if (cnt_q == CNT_MID) state_d = rxs ? S_IDLE : S_DATA;
        S_DATA:   if (cnt_q == CNT_LAST && bit_idx_q == BIT_LAST)
                    state_d = par_en ? S_PARITY : S_STOP;
        S_PARITY: if (cnt_q == CNT_LAST) state_d = S_STOP;
        S_STOP:   if (cnt_q == CNT_LAST) state_d = rxs ? S_IDLE : S_BREAK;
        S_BREAK:  if (rxs) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_q != S_IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_type_q <= 2'b00;
      par_mis_q  <= 1'b0;
      data_out_q <= '1;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (sample_tick_i) begin
        case (state_q)
          S_IDLE: begin
            cnt_q <= '0;
            if (!rxs) begin
              par_type_q <= parity_type_i;
              par_mis_q  <= 1'b0;
            end
          end
          S_START: begin
            if (cnt_q == CNT_MID) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DATA: begin
            if (cnt_q == CNT_LAST) begin
              shift_q[bit_idx_q] <= rxs;
              bit_idx_q          <= bit_idx_q + 1'b1;
              cnt_q              <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_PARITY: begin
            if (cnt_q == CNT_LAST) begin
              par_mis_q <= rxs ^ par_exp;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_STOP: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q      <= '0;
              data_out_q <= shift_q;
              perr_q     <= par_en & par_mis_q;
              serr_q     <= ~rxs;
              valid_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: cnt_q <= '0;
        endcase
      end
    end
  end

  assign data_out_o     = data_out_q;
  assign data_valid_o   = valid_q;
  assign parity_error_o = perr_q;
  assign stop_error_o   = serr_q;
  assign busy_o         = busy_d;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level expectation queue checked every cycle,
// plus literal expectations after each directed frame.
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int BITCLK   = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] ptype = 2'b00;
  logic [7:0] dout;
  logic       dv, perr, serr, busy;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .sample_tick_i(tick), .rx_in_i(rx),
    .parity_type_i(ptype), .data_out_o(dout), .data_valid_o(dv),
    .parity_error_o(perr), .stop_error_o(serr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] m_d  = 8'hFF;
  logic       m_pe = 1'b0;
  logic       m_se = 1'b0;
  bit         chk_en = 1'b0;
  int         n_vec = 0, n_err = 0, n_valid = 0;
  longint     cyc = 0, last_v_cyc = 0, prev_v_cyc = 0;

  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (k % TICK_DIV == TICK_DIV - 1);
      k++;
    end
  end

  always @(posedge clk) cyc++;

  // Compare process: outputs must match the last completed frame on every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (dv) begin
          n_valid++;
          prev_v_cyc = last_v_cyc;
          last_v_cyc = cyc;
          if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: data_valid=1 data_out=%h with no frame outstanding", dout);
          end else begin
            e = expq.pop_front();
            m_d = e.d;
            m_pe = e.pe;
            m_se = e.se;
          end
        end
        n_vec++;
        if ({dout, perr, serr} !== {m_d, m_pe, m_se}) begin
          n_err++;
          $display("FAIL out_track @%0t: got data=%h pe=%b se=%b expected data=%h pe=%b se=%b",
                   $time, dout, perr, serr, m_d, m_pe, m_se);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(logic b);
    rx = b;
    clks(BITCLK);
  endtask

  task automatic send_frame(logic [7:0] d, logic [1:0] pt, logic pbit, logic stop);
    exp_t e;
    int   ones;
    ones = $countones(d) + int'(pbit);
    e.d  = d;
    e.se = ~stop;
    if (pt == 2'b01)      e.pe = (ones % 2 != 1);
    else if (pt == 2'b10) e.pe = (ones % 2 != 0);
    else                  e.pe = 1'b0;
    expq.push_back(e);
    ptype = pt;
    drive_bit(1'b0);
    ptype = ~pt;
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      if (i == 0) chk("busy_in_frame", 32'(busy), 32'd1);
    end
    if (pt == 2'b01 || pt == 2'b10) drive_bit(pbit);
    drive_bit(stop);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    rst_n = 1'b0;
    clks(5);
    chk("rst_data_out", 32'(dout), 32'hFF);
    chk("rst_valid", 32'(dv), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    chk("rst_serr", 32'(serr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    clks(BITCLK);

    v0 = n_valid;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1);
    chk("a5_count", 32'(n_valid), 32'(v0 + 1));
    chk("a5_data", 32'(dout), 32'hA5);
    chk("a5_perr", 32'(perr), 32'd0);
    chk("a5_serr", 32'(serr), 32'd0);
    chk("a5_busy_after", 32'(busy), 32'd0);
    clks(BITCLK);

    send_frame(8'h3C, 2'b10, 1'b0, 1'b1);
    chk("3c_even_data", 32'(dout), 32'h3C);
    chk("3c_even_perr", 32'(perr), 32'd0);
    clks(BITCLK);
    send_frame(8'h3C, 2'b01, 1'b0, 1'b1);
    chk("3c_odd_data", 32'(dout), 32'h3C);
    chk("3c_odd_perr", 32'(perr), 32'd1);
    clks(BITCLK);

    v0 = n_valid;
    rx = 1'b0;
    clks(4 * TICK_DIV);
    chk("glitch_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    clks(BITCLK);
    chk("glitch_busy_drop", 32'(busy), 32'd0);
    chk("glitch_no_valid", 32'(n_valid), 32'(v0));
    chk("glitch_data_hold", 32'(dout), 32'h3C);
    clks(BITCLK);

    v0 = n_valid;
    send_frame(8'h55, 2'b00, 1'b0, 1'b0);
    chk("brk_count", 32'(n_valid), 32'(v0 + 1));
    chk("brk_data", 32'(dout), 32'h55);
    chk("brk_serr", 32'(serr), 32'd1);
    clks(29 * BITCLK);
    chk("brk_busy_low", 32'(busy), 32'd1);
    chk("brk_no_frame", 32'(n_valid), 32'(v0 + 1));
    rx = 1'b1;
    clks(BITCLK);
    chk("brk_busy_release", 32'(busy), 32'd0);
    send_frame(8'h0F, 2'b00, 1'b0, 1'b1);
    chk("after_brk_data", 32'(dout), 32'h0F);
    chk("after_brk_serr", 32'(serr), 32'd0);
    clks(BITCLK);

    v0 = n_valid;
    send_frame(8'h01, 2'b01, 1'b0, 1'b1);
    chk("b2b_first_data", 32'(dout), 32'h01);
    chk("b2b_first_perr", 32'(perr), 32'd0);
    send_frame(8'hFE, 2'b01, 1'b0, 1'b1);
    chk("b2b_second_data", 32'(dout), 32'hFE);
    chk("b2b_second_perr", 32'(perr), 32'd0);
    chk("b2b_count", 32'(n_valid), 32'(v0 + 2));
    chk("b2b_spacing", 32'(last_v_cyc - prev_v_cyc), 32'(11 * BITCLK));
    clks(BITCLK);

    v0 = n_valid;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    clks(BITCLK / 2);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    m_d = 8'hFF;
    m_pe = 1'b0;
    m_se = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", 32'(dout), 32'hFF);
    chk("rst_mid_busy_low", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(dv), 32'd0);
    clks(4);
    rx = 1'b1;
    rst_n = 1'b1;
    clks(BITCLK);
    chk("rst_mid_no_valid", 32'(n_valid), 32'(v0));
    send_frame(8'h81, 2'b00, 1'b0, 1'b1);
    chk("post_rst_data", 32'(dout), 32'h81);
    chk("post_rst_count", 32'(n_valid), 32'(v0 + 1));
    clks(BITCLK);
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the UART transmit path.
- Recovers 8-bit frames from the serial line: start bit, 8 data bits LSB first, optional odd/even parity bit, one stop bit.
- Uses 16x oversampling driven by an external sample-tick enable.
- Presents each received byte with a one-cycle valid strobe and per-frame parity/stop error flags.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be an even value from 8 to 16.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sample_tick  input  1  one-clock enable pulse at OVERSAMPLE x baud rate.
- rx_in  input  1  asynchronous serial line; idles high.
- parity_type  input  2  00 = none, 01 = odd, 10 = even, 11 = none.
- data_out  output  8  last received byte.
- data_valid  output  1  one-clock strobe marking a completed frame.
- parity_error  output  1  parity mismatch on the last frame.
- stop_error  output  1  stop bit sampled low on the last frame.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, reset_n low) forces these values until release:
  - data_out = 8'hFF
  - data_valid = 0, parity_error = 0, stop_error = 0, busy = 0
  - FSM = IDLE
  - synchronizer flops = 1
  - tick counter = 0, bit index = 0
- Reset mid-frame aborts the frame; no data_valid is produced for it.
- rx_in passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- The FSM and tick counter advance only on cycles where sample_tick = 1; otherwise all state holds.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - On a tick with rxs = 0: go to START, counter = 0, latch parity_type into an internal register.
  - parity_type changes mid-frame are ignored.
- START:
  - Counter increments each tick.
  - At counter = OVERSAMPLE/2-1 (7) the start bit is checked. If rxs = 0: go to DATA, counter = 0, bit index = 0.
  - If rxs = 1 at that check, it is a false start: return to IDLE with no outputs changed.
- DATA:
  - At counter = OVERSAMPLE-1 (15), sample rxs into shift-register position [bit index], LSB first, then set counter = 0.
  - After bit 7: go to PARITY if the latched parity type is 01/10, else go to STOP.
- PARITY:
  - Sample at counter = 15.
  - Expected bit: even = XOR of the 8 data bits; odd = inverse of that XOR.
  - Store the mismatch result internally.
- STOP: sample at counter = 15.
  - If rxs = 1: go to IDLE.
  - If rxs = 0: go to BREAK.
  - In both cases the frame completes on this tick.
- BREAK: stay until a tick with rxs = 1, then go to IDLE. No new frame is detected while in BREAK.
- Frame completion (clock after the stop-sampling tick):
  - data_out updates to the shifted byte, even when an error flag is set.
  - parity_error updates to the stored mismatch; forced 0 when parity is none.
  - stop_error updates to the inverse of the sampled stop bit.
  - data_valid = 1 for exactly that one clock.
  - Error flags and data_out hold until the next frame completion.
- Timing:
  - Sampling point is mid-bit ±1 tick.
  - Latency from the stop-bit sample tick to data_valid is 1 clock.
  - Back-to-back frames are accepted: IDLE can detect a new start on the first tick after returning from STOP.
- busy is high in START, DATA, PARITY, STOP and BREAK.
- No overrun detection: a new frame overwrites data_out regardless of whether the consumer read the previous one.

Test Plan:
- 0xA5, parity none, stop = 1 → data_valid pulse once; data_out = 8'hA5; parity_error = 0; stop_error = 0; busy falls after the stop sample.
- 0x3C, even parity, parity bit = 0 → data_out = 8'h3C, parity_error = 0. Same byte with odd parity selected → parity_error = 1.
- rx_in low for 4 ticks then high (glitch) → START aborts at the mid-bit check; no data_valid; data_out keeps its previous value; busy drops.
- 0x55 with stop bit 0, line held low 30 bit periods, then high → data_valid with stop_error = 1 and data_out = 8'h55. No further frame while low; the next frame 0x0F after release → data_valid, data_out = 8'h0F, stop_error = 0.
- Two back-to-back frames 0x01 then 0xFE (zero idle time), odd parity → two data_valid pulses about 11 bit periods apart, data_out 8'h01 then 8'hFE, parity_error = 0 both times.
- reset_n asserted during DATA bit 4 of 0x81 → outputs immediately at reset values (data_out = 8'hFF); no data_valid; a following 0x81 frame after release is received correctly.
